// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared 512Kx8 external SRAM. Video fetches always
// win; CPU accesses are stretched with cpu_wait_n. All outputs are registered.
module ram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        vid_overrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        asic_is_using_ram
);

  localparam logic [2:0] LastCnt = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StVid, StCpuRd, StCpuWr} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        vid_pend_q;
  logic [18:0] vid_addr_q;
  // Cleared by an ack; re-armed only once cpu_req has been seen low.
  logic        cpu_armed_q;

  logic last, arb, vid_done, cpu_done, take_vid, take_cpu, vid_consume, vid_live;

  // Arbitration point and grant decisions for the current cycle
  always_comb begin
    last        = (state_q != StIdle) && (cnt_q == LastCnt);
    arb         = (state_q == StIdle) || last;
    vid_done    = (state_q == StVid) && last;
    cpu_done    = ((state_q == StCpuRd) || (state_q == StCpuWr)) && last;
    take_vid    = vid_pend_q || vid_req;
    // The request being acked this cycle must not be granted again.
    take_cpu    = cpu_req && cpu_armed_q && !cpu_done;
    vid_consume = arb && vid_pend_q;
    // A live request granted directly never needs latching.
    vid_live    = arb && !vid_pend_q && vid_req;
  end

  // Single FSM: sequences SRAM strobes and produces all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      cnt_q             <= 3'd0;
      vid_pend_q        <= 1'b0;
      vid_addr_q        <= 19'd0;
      cpu_armed_q       <= 1'b1;
      vid_data          <= 8'd0;
      vid_valid         <= 1'b0;
      vid_overrun       <= 1'b0;
      cpu_rdata         <= 8'd0;
      cpu_ack           <= 1'b0;
      cpu_wait_n        <= 1'b1;
      sram_addr         <= 19'd0;
      sram_dout         <= 8'd0;
      sram_oe_n         <= 1'b1;
      sram_we_n         <= 1'b1;
      asic_is_using_ram <= 1'b0;
    end else begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;

      // Video request latch; a newer request overwrites the pending address.
      if (vid_req && !vid_live) begin
        if (vid_pend_q && !vid_consume) vid_overrun <= 1'b1;
        vid_pend_q <= 1'b1;
        vid_addr_q <= vid_addr;
      end else if (vid_consume) begin
        vid_pend_q <= 1'b0;
      end

      if (vid_done) begin
        vid_data  <= sram_din;
        vid_valid <= 1'b1;
      end

      if (cpu_done) begin
        cpu_ack     <= 1'b1;
        cpu_armed_q <= 1'b0;
        if (state_q == StCpuRd) cpu_rdata <= sram_din;
      end else if (!cpu_req) begin
        cpu_armed_q <= 1'b1;
      end

      cpu_wait_n <= cpu_done ? 1'b1 : !(cpu_req && cpu_armed_q);

      if (arb) begin
        cnt_q <= 3'd0;
        if (take_vid) begin
          state_q           <= StVid;
          sram_addr         <= vid_pend_q ? vid_addr_q : vid_addr;
          sram_oe_n         <= 1'b0;
          sram_we_n         <= 1'b1;
          asic_is_using_ram <= 1'b1;
        end else if (take_cpu) begin
          sram_addr         <= cpu_addr;
          asic_is_using_ram <= 1'b0;
          if (cpu_we) begin
            state_q   <= StCpuWr;
            sram_dout <= cpu_wdata;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b0;
          end else begin
            state_q   <= StCpuRd;
            sram_oe_n <= 1'b0;
            sram_we_n <= 1'b1;
          end
        end else begin
          state_q           <= StIdle;
          sram_oe_n         <= 1'b1;
          sram_we_n         <= 1'b1;
          asic_is_using_ram <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q + 3'd1;
        // Release write enable for the final hold cycle of a write.
        if ((state_q == StCpuWr) && (cnt_q + 3'd1 == LastCnt)) sram_we_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run checked
// against a slot-level behavioural model of the arbiter.
module tb_ram_arbiter;

  localparam int unsigned AC = 3;
  localparam int KVid = 0;
  localparam int KRd  = 1;
  localparam int KWr  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vid_req;
  logic [18:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait_n;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        asic_is_using_ram;

  logic        din_ovr_en = 1'b0;
  logic [7:0]  din_ovr = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .vid_req           (vid_req),
    .vid_addr          (vid_addr),
    .vid_data          (vid_data),
    .vid_valid         (vid_valid),
    .vid_overrun       (vid_overrun),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_ack           (cpu_ack),
    .cpu_wait_n        (cpu_wait_n),
    .sram_addr         (sram_addr),
    .sram_dout         (sram_dout),
    .sram_din          (sram_din),
    .sram_oe_n         (sram_oe_n),
    .sram_we_n         (sram_we_n),
    .asic_is_using_ram (asic_is_using_ram)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hash(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] dval(input logic [18:0] a);
    return din_ovr_en ? din_ovr : hash(a);
  endfunction

  // SRAM stand-in: contents are a fixed function of address.
  always_comb sram_din = din_ovr_en ? din_ovr : hash(sram_addr);

  // ---------------- reference model (access slots, counted down) ----------------
  int          m_busy = 0;
  int          m_kind = KVid;
  logic [18:0] m_addr = '0;
  logic [7:0]  m_dout = '0;
  logic        m_pend = 1'b0;
  logic [18:0] m_paddr = '0;
  logic        m_armed = 1'b1;
  logic        m_over = 1'b0;
  logic        e_valid = 1'b0;
  logic [7:0]  e_vdata = '0;
  logic        e_ack = 1'b0;
  logic [7:0]  e_rdata = '0;
  logic        e_wait_n = 1'b1;

  always @(posedge clk) begin : model
    bit free, fin_vid, fin_cpu, cpu_ok, consumed, live;
    if (!rst_n) begin
      m_busy = 0; m_addr = '0; m_dout = '0; m_pend = 1'b0; m_armed = 1'b1;
      m_over = 1'b0; e_valid = 1'b0; e_vdata = '0; e_ack = 1'b0; e_rdata = '0;
      e_wait_n = 1'b1;
    end else begin
      free    = (m_busy <= 1);
      fin_vid = (m_busy == 1) && (m_kind == KVid);
      fin_cpu = (m_busy == 1) && (m_kind != KVid);
      e_valid = 1'b0;
      e_ack   = 1'b0;
      if (fin_vid) begin e_valid = 1'b1; e_vdata = dval(m_addr); end
      if (fin_cpu) begin
        e_ack = 1'b1;
        if (m_kind == KRd) e_rdata = dval(m_addr);
      end
      cpu_ok   = cpu_req && m_armed && !fin_cpu;
      e_wait_n = fin_cpu ? 1'b1 : !(cpu_req && m_armed);
      if (fin_cpu) m_armed = 1'b0;
      else if (!cpu_req) m_armed = 1'b1;
      consumed = 0;
      live     = 0;
      if (free) begin
        if (m_pend) begin
          m_kind = KVid; m_addr = m_paddr; m_busy = AC; consumed = 1;
        end else if (vid_req) begin
          m_kind = KVid; m_addr = vid_addr; m_busy = AC; live = 1;
        end else if (cpu_ok) begin
          m_kind = cpu_we ? KWr : KRd;
          m_addr = cpu_addr;
          if (cpu_we) m_dout = cpu_wdata;
          m_busy = AC;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_busy = m_busy - 1;
      end
      if (vid_req && !live) begin
        if (m_pend && !consumed) m_over = 1'b1;
        m_pend  = 1'b1;
        m_paddr = vid_addr;
      end else if (consumed) begin
        m_pend = 1'b0;
      end
    end
  end

  logic [49:0] obs_vec, exp_vec;
  always_comb begin
    obs_vec = {vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata, cpu_wait_n,
               sram_addr, sram_dout, sram_oe_n, sram_we_n, asic_is_using_ram};
    exp_vec = {e_valid, e_vdata, m_over, e_ack, e_rdata, e_wait_n, m_addr, m_dout,
               !(m_busy > 0 && m_kind != KWr), !(m_busy > 1 && m_kind == KWr),
               (m_busy > 0 && m_kind == KVid)};
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [49:0] rst_vec;
    rst_vec = {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 19'h0, 8'h00, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    repeat (3) cyc();
    n_vec++;
    if (obs_vec !== rst_vec) begin
      n_err++;
      $display("FAIL reset_values: got %h, want %h", obs_vec, rst_vec);
    end
    rst_n = 1'b1;
    repeat (2) cyc();
    n_vec++;
    if ({sram_oe_n, sram_we_n, cpu_wait_n, vid_valid} !== 4'b1110) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b, want 1110",
               {sram_oe_n, sram_we_n, cpu_wait_n, vid_valid});
    end
  endtask

  task automatic test_video();
    din_ovr_en = 1'b1;
    din_ovr    = 8'hAB;
    vid_req    = 1'b1;
    vid_addr   = 19'h12345;
    for (int k = 1; k <= int'(AC) + 2; k++) begin
      cyc();
      vid_req = 1'b0;
      n_vec++;
      if (k <= int'(AC)) begin
        if ({asic_is_using_ram, sram_oe_n, vid_valid, sram_addr} !== {3'b100, 19'h12345}) begin
          n_err++;
          $display("FAIL video_access k=%0d: got %b %b %b %h, want 1 0 0 12345", k,
                   asic_is_using_ram, sram_oe_n, vid_valid, sram_addr);
        end
      end else if (k == int'(AC) + 1) begin
        if ({vid_valid, vid_data, asic_is_using_ram} !== {1'b1, 8'hAB, 1'b0}) begin
          n_err++;
          $display("FAIL video_valid: got v=%b d=%h asic=%b, want v=1 d=ab asic=0",
                   vid_valid, vid_data, asic_is_using_ram);
        end
      end else if (vid_valid !== 1'b0) begin
        n_err++;
        $display("FAIL video_valid_pulse: got %b, want 0", vid_valid);
      end
    end
    din_ovr_en = 1'b0;
  endtask

  task automatic test_cpu_write();
    int we_low = 0, wait_low = 0, acks = 0, ack_at = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h7FFFF; cpu_wdata = 8'h5A;
    for (int k = 1; k <= int'(AC) + 4; k++) begin
      cyc();
      if (!sram_we_n) we_low++;
      if (!cpu_wait_n) wait_low++;
      if (cpu_ack) begin acks++; ack_at = k; cpu_req = 1'b0; end
      if (k <= int'(AC)) begin
        n_vec++;
        if ({sram_addr, sram_dout, sram_oe_n, sram_we_n} !==
            {19'h7FFFF, 8'h5A, 1'b1, (k == int'(AC))}) begin
          n_err++;
          $display("FAIL write_strobes k=%0d: got %h %h %b %b, want 7ffff 5a 1 %b", k,
                   sram_addr, sram_dout, sram_oe_n, sram_we_n, (k == int'(AC)));
        end
      end
    end
    n_vec++;
    if (we_low != int'(AC) - 1) begin
      n_err++; $display("FAIL write_we_low_cycles: got %0d, want %0d", we_low, AC - 1);
    end
    n_vec++;
    if (wait_low != int'(AC)) begin
      n_err++; $display("FAIL write_wait_cycles: got %0d, want %0d", wait_low, AC);
    end
    n_vec++;
    if (acks != 1 || ack_at != int'(AC) + 1) begin
      n_err++;
      $display("FAIL write_ack: got %0d acks at %0d, want 1 at %0d", acks, ack_at, AC + 1);
    end
  endtask

  task automatic test_collision();
    logic [18:0] va, ca;
    logic [18:0] want_addr;
    va = 19'h54321; ca = 19'h0ABCD;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    vid_req = 1'b1; vid_addr = va;
    for (int k = 1; k <= 2 * int'(AC) + 3; k++) begin
      cyc();
      vid_req   = 1'b0;
      want_addr = (k <= int'(AC)) ? va : ca;
      n_vec++;
      if ({asic_is_using_ram, sram_oe_n, cpu_wait_n, cpu_ack, sram_addr} !==
          {(k <= int'(AC)), !(k <= 2 * int'(AC)), !(k <= 2 * int'(AC)),
           (k == 2 * int'(AC) + 1), want_addr}) begin
        n_err++;
        $display("FAIL collision k=%0d: got asic=%b oe=%b wait=%b ack=%b a=%h", k,
                 asic_is_using_ram, sram_oe_n, cpu_wait_n, cpu_ack, sram_addr);
      end
      if (k == int'(AC) + 1) begin
        n_vec++;
        if (vid_valid !== 1'b1 || vid_data !== hash(va)) begin
          n_err++;
          $display("FAIL collision_vdata: got %b %h, want 1 %h", vid_valid, vid_data, hash(va));
        end
      end
      if (k == 2 * int'(AC) + 1) begin
        n_vec++;
        if (cpu_rdata !== hash(ca)) begin
          n_err++; $display("FAIL collision_rdata: got %h, want %h", cpu_rdata, hash(ca));
        end
      end
      if (cpu_ack) cpu_req = 1'b0;
    end
  endtask

  task automatic test_overrun();
    logic [18:0] a1, a2;
    int vcycles = 0, bad_addr = 0, valids = 0;
    a1 = 19'h01111; a2 = 19'h02222;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00300; cpu_wdata = 8'hC3;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 2) begin
        n_vec++;
        if (vid_overrun !== 1'b0) begin
          n_err++; $display("FAIL overrun_early: got %b, want 0", vid_overrun);
        end
      end
      if (k == 3) begin
        n_vec++;
        if (vid_overrun !== 1'b1) begin
          n_err++; $display("FAIL overrun_set: got %b, want 1", vid_overrun);
        end
      end
      if (asic_is_using_ram) begin
        vcycles++;
        if (sram_addr !== a2) bad_addr++;
      end
      if (vid_valid) begin
        valids++;
        n_vec++;
        if (vid_data !== hash(a2)) begin
          n_err++; $display("FAIL overrun_vdata: got %h, want %h", vid_data, hash(a2));
        end
      end
      if (cpu_ack) cpu_req = 1'b0;
      vid_req  = (k == 1) || (k == 2);
      vid_addr = (k == 1) ? a1 : a2;
    end
    n_vec++;
    if (vcycles != int'(AC) || bad_addr != 0 || valids != 1) begin
      n_err++;
      $display("FAIL overrun_single_fetch: got %0d cycles %0d bad %0d valid, want %0d 0 1",
               vcycles, bad_addr, valids, AC);
    end
    n_vec++;
    if (vid_overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_sticky: got %b, want 1", vid_overrun);
    end
  endtask

  task automatic test_held_req();
    int acks = 0, oe_low = 0, wait_low = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00042;
    for (int k = 1; k <= int'(AC) + 12; k++) begin
      cyc();
      if (cpu_ack) acks++;
      if (!sram_oe_n) oe_low++;
      if (!cpu_wait_n) wait_low++;
    end
    cpu_req = 1'b0;
    n_vec++;
    if (acks != 1 || oe_low != int'(AC) || wait_low != int'(AC)) begin
      n_err++;
      $display("FAIL held_req_once: got acks=%0d oe=%0d wait=%0d, want 1 %0d %0d",
               acks, oe_low, wait_low, AC, AC);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int acks = 0, busy = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h11111;
    cyc();
    n_vec++;
    if (sram_oe_n !== 1'b0 || cpu_wait_n !== 1'b0) begin
      n_err++; $display("FAIL midreset_pre: got oe=%b wait=%b, want 0 0", sram_oe_n, cpu_wait_n);
    end
    rst_n = 1'b0; cpu_req = 1'b0;
    cyc();
    n_vec++;
    if ({sram_oe_n, sram_we_n, cpu_wait_n, cpu_ack, vid_overrun, asic_is_using_ram, sram_addr}
        !== {6'b111000, 19'h0}) begin
      n_err++;
      $display("FAIL midreset_outputs: got oe=%b we=%b wait=%b ack=%b ovr=%b asic=%b a=%h",
               sram_oe_n, sram_we_n, cpu_wait_n, cpu_ack, vid_overrun, asic_is_using_ram,
               sram_addr);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= int'(AC) + 3; k++) begin
      cyc();
      if (cpu_ack) acks++;
      if (!sram_oe_n || asic_is_using_ram) busy++;
    end
    n_vec++;
    if (acks != 0 || busy != 0) begin
      n_err++; $display("FAIL midreset_idle: got acks=%0d busy=%0d, want 0 0", acks, busy);
    end
  endtask

  task automatic test_random();
    int hold = -1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random cycle %0d: got %h, want %h", i, obs_vec, exp_vec);
      end
      vid_req  = ($urandom_range(0, 4) == 0);
      vid_addr = 19'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      if (cpu_req) begin
        if (cpu_ack) hold = $urandom_range(0, 3);
        if (hold == 0) begin
          cpu_req = 1'b0; hold = -1;
        end else if (hold > 0) begin
          hold--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom);
        cpu_addr  = 19'($urandom);
        cpu_wdata = 8'($urandom);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_video();
    test_cpu_write();
    test_collision();
    test_overrun();
    test_held_req();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 512K×8 external SRAM between two requesters: the ASIC video fetcher and the Z80 CPU.
- Video fetches have absolute priority. CPU accesses are stretched through `cpu_wait_n`.
- Sits between the ASIC (`vramaddr`/`cpuramaddr` sources) and the SRAM pins. Sequences address, output-enable and write-enable timing, and reports `asic_is_using_ram`.

Parameters:
ACCESS_CYCLES, 2, clk cycles per SRAM access (legal range 2–7)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
vid_req  in  1  one-cycle pulse: video fetch request
vid_addr  in  19  video fetch address, sampled with vid_req
vid_data  out  8  fetched video byte
vid_valid  out  1  one-cycle pulse: vid_data valid
vid_overrun  out  1  sticky: vid_req arrived while a video request was still pending
cpu_req  in  1  level: CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  in  19  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data, valid when cpu_ack = 1
cpu_ack  out  1  one-cycle pulse: CPU access complete
cpu_wait_n  out  1  low while a CPU request is outstanding and not yet acked
sram_addr  out  19  SRAM address
sram_dout  out  8  SRAM write data
sram_din  in  8  SRAM read data
sram_oe_n  out  1  SRAM output enable, active-low
sram_we_n  out  1  SRAM write enable, active-low
asic_is_using_ram  out  1  high while in the VID state

Behaviour:
- Interface: one clock, `clk`. Reset is synchronous and active-low, `rst_n`.
- All outputs are registered.
- Reset values:
  - `sram_addr` = 0, `sram_dout` = 0
  - `sram_oe_n` = 1, `sram_we_n` = 1
  - `vid_valid` = 0, `vid_data` = 0, `vid_overrun` = 0
  - `cpu_ack` = 0, `cpu_rdata` = 0, `cpu_wait_n` = 1
  - `asic_is_using_ram` = 0
  - state = IDLE, `vid_pend` = 0, cycle counter = 0
- Video request latch:
  - `vid_req` = 1 sets `vid_pend` and captures `vid_addr`.
  - If `vid_pend` is already 1 and not being consumed that cycle, `vid_overrun` sets. The new address still overwrites the old one.
  - `vid_overrun` clears only on reset.
- States: IDLE, VID, CPU_RD, CPU_WR. Each access state lasts exactly ACCESS_CYCLES cycles, counted by a 3-bit counter that starts at 0.
- Arbitration is evaluated in IDLE and in the last cycle of every access state:
  - If `vid_pend` = 1 or `vid_req` = 1: go to VID, using the latched address or the live `vid_addr` respectively.
  - Else if `cpu_req` = 1 and the request is not yet acked: go to CPU_WR if `cpu_we` = 1, otherwise CPU_RD.
  - Else: go to IDLE.
- Back-to-back accesses insert no idle cycle.
- VID state:
  - `sram_addr` = video address, `sram_oe_n` = 0, `asic_is_using_ram` = 1.
  - `vid_pend` clears on entry, unless `vid_req` is asserted in that same cycle.
  - On the last cycle, `sram_din` is captured into `vid_data`, and `vid_valid` = 1 on the following cycle.
- CPU_RD state:
  - `sram_addr` = `cpu_addr`, `sram_oe_n` = 0.
  - On the last cycle, `sram_din` is captured into `cpu_rdata`, and `cpu_ack` = 1 on the following cycle.
- CPU_WR state:
  - `sram_addr` = `cpu_addr`, `sram_dout` = `cpu_wdata`, `sram_oe_n` = 1.
  - `sram_we_n` = 0 for cycles 0 .. ACCESS_CYCLES−2 and 1 in the last cycle (data/address hold).
  - `cpu_ack` = 1 on the following cycle.
- Latency from an idle arbiter: request at edge N → access occupies cycles N+1 .. N+ACCESS_CYCLES → `vid_valid`/`cpu_ack` at N+ACCESS_CYCLES+1.
- `cpu_wait_n` goes to 0 the cycle after `cpu_req` is first seen unacked. It returns to 1 in the same cycle `cpu_ack` = 1.
- After an ack, the arbiter ignores `cpu_req` until it has been seen low for one cycle. A held request therefore never double-executes.
- The CPU may be starved indefinitely by continuous video requests. This is by design, because video timing is fixed by the ASIC.
- Reset asserted mid-access: all outputs return to reset values at the next edge. No ack or valid is issued for the aborted access, and the pending state is discarded.

Test Plan:
- `vid_req` pulse with `vid_addr` = 0x12345 from IDLE, `sram_din` = 0xAB → VID for 2 cycles with `sram_addr` = 0x12345 and `sram_oe_n` = 0; `vid_valid` = 1 and `vid_data` = 0xAB 3 cycles after the request.
- CPU write: `cpu_addr` = 0x7FFFF, `cpu_wdata` = 0x5A, ACCESS_CYCLES = 3 → `sram_we_n` low for exactly 2 cycles then high for 1; `cpu_ack` pulses once; `cpu_wait_n` low for 3 cycles.
- `cpu_req` (read) and `vid_req` in the same cycle → VID first, CPU_RD immediately after with no idle cycle; `cpu_ack` at cycle 5 (ACCESS_CYCLES = 2); `cpu_wait_n` low throughout.
- Two `vid_req` pulses 1 cycle apart while a CPU_WR is in progress → `vid_overrun` = 1 (sticky); a single VID access uses the second address.
- `cpu_req` held high for 10 cycles after `cpu_ack` → no second access, `cpu_ack` pulses exactly once.
- `rst_n` = 0 in cycle 1 of CPU_RD → next cycle `sram_oe_n` = 1, `cpu_wait_n` = 1, no `cpu_ack`, state IDLE, `vid_overrun` = 0.
